// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_boot_loader_if
//  Description : Instruction-memory write port driven by the UART boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic [15:0]       din;
    logic [ADDR_W-1:0] addr;
    logic              w_en;

    modport master (output din, output addr, output w_en);
    modport slave  (input  din, input  addr, input  w_en);
endinterface
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_boot_loader
//  Description : Holds the CPU in reset, loads a framed image over UART into
//                instruction memory, replies ACK/NAK, then releases the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int F_CPU        = 16000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 12,
    parameter int BOOT_WAIT    = 16000000,
    parameter int BYTE_TIMEOUT = 1600000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       boot_rx,
    output logic                       boot_tx,
    uart_boot_loader_if.master         imem,
    output logic                       cpu_hold,
    output logic                       busy,
    output logic                       load_error
);

    localparam int CLKS_PER_BIT = F_CPU / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int WAIT_W       = $clog2(BOOT_WAIT + 1);
    localparam int TO_W         = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  ACK_BYTE  = 8'h06;
    localparam logic [7:0]  NAK_BYTE  = 8'h15;
    localparam logic [16:0] MAX_LEN   = 17'd1 << ADDR_W;

    // ---------------------------------------------------------------- RX path
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t             r_rx_state;
    logic                  r_rx_meta, r_rx_sync, r_rx_prev;
    logic [BIT_CNT_W-1:0]  r_rx_cnt;
    logic [2:0]            r_rx_idx;
    logic [7:0]            r_rx_shift;
    logic                  r_byte_valid;
    logic                  r_frame_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_cnt     <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= boot_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start-bit recheck rejects short low glitches
                    if (r_rx_cnt == BIT_CNT_W'(HALF_BIT - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_idx   <= r_rx_idx + 1'b1;
                        if (r_rx_idx == 3'd7)
                            r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_rx_cnt     <= '0;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                        r_rx_state   <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ frame FSM
    typedef enum logic [2:0] {
        WAIT_SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, REPLY, RUN
    } state_t;

    state_t                r_state;
    logic                  r_cpu_hold, r_busy, r_load_error, r_tx;
    logic                  r_w_en;
    logic [ADDR_W-1:0]     r_addr;
    logic [15:0]           r_din;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [7:0]            r_len_lo, r_data_lo, r_chk;
    logic [15:0]           r_len, r_word_cnt;
    logic [8:0]            r_tx_shift;
    logic [BIT_CNT_W-1:0]  r_tx_cnt;
    logic [3:0]            r_tx_bits;
    logic                  r_reply_ack;

    logic                  w_in_frame, w_timeout, w_start_reply;
    logic [7:0]            w_reply_byte;
    logic [15:0]           w_len;

    assign w_in_frame = r_state inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK};
    assign w_timeout  = (r_to_cnt == TO_W'(BYTE_TIMEOUT - 1)) && !r_byte_valid;
    assign w_len      = {r_rx_shift, r_len_lo};

    // Every path into REPLY is decided here so the FSM has a single entry point
    always_comb begin
        w_start_reply = 1'b0;
        w_reply_byte  = NAK_BYTE;
        if (w_in_frame) begin
            if (r_frame_err || w_timeout) begin
                w_start_reply = 1'b1;
            end else if (r_byte_valid) begin
                if (r_state == LEN_HI && {1'b0, w_len} > MAX_LEN) begin
                    w_start_reply = 1'b1;
                end else if (r_state == CHECK) begin
                    w_start_reply = 1'b1;
                    w_reply_byte  = (r_rx_shift == r_chk) ? ACK_BYTE : NAK_BYTE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= WAIT_SYNC;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_load_error <= 1'b0;
            r_tx         <= 1'b1;
            r_w_en       <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_wait_cnt   <= '0;
            r_to_cnt     <= '0;
            r_len_lo     <= '0;
            r_data_lo    <= '0;
            r_chk        <= '0;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_tx_shift   <= '1;
            r_tx_cnt     <= '0;
            r_tx_bits    <= '0;
            r_reply_ack  <= 1'b0;
        end else begin
            r_w_en   <= 1'b0;
            if (r_w_en)
                r_addr <= r_addr + 1'b1;
            r_to_cnt <= (w_in_frame && !r_byte_valid) ? r_to_cnt + 1'b1 : '0;

            if (w_start_reply) begin
                r_state     <= REPLY;
                r_reply_ack <= (w_reply_byte == ACK_BYTE);
                r_tx        <= 1'b0;
                r_tx_shift  <= {1'b1, w_reply_byte};
                r_tx_cnt    <= '0;
                r_tx_bits   <= '0;
            end else begin
                case (r_state)
                    WAIT_SYNC: begin
                        if (r_byte_valid && r_rx_shift == SYNC_BYTE) begin
                            r_state      <= LEN_LO;
                            r_busy       <= 1'b1;
                            r_load_error <= 1'b0;
                            r_addr       <= '0;
                            r_chk        <= '0;
                        end else if (r_wait_cnt == WAIT_W'(BOOT_WAIT - 1)) begin
                            r_state    <= RUN;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    LEN_LO: begin
                        if (r_byte_valid) begin
                            r_len_lo <= r_rx_shift;
                            r_state  <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (r_byte_valid) begin
                            r_len      <= w_len;
                            r_word_cnt <= '0;
                            r_state    <= (w_len == 16'd0) ? CHECK : DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        if (r_byte_valid) begin
                            r_data_lo <= r_rx_shift;
                            r_chk     <= r_chk + r_rx_shift;
                            r_state   <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        if (r_byte_valid) begin
                            r_w_en     <= 1'b1;
                            r_din      <= {r_rx_shift, r_data_lo};
                            r_chk      <= r_chk + r_rx_shift;
                            r_word_cnt <= r_word_cnt + 16'd1;
                            r_state    <= ((r_word_cnt + 16'd1) == r_len) ? CHECK : DATA_LO;
                        end
                    end
                    CHECK: begin
                        r_state <= CHECK;
                    end
                    REPLY: begin
                        if (r_tx_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
                            r_tx_cnt <= '0;
                            if (r_tx_bits == 4'd9) begin
                                r_tx   <= 1'b1;
                                r_busy <= 1'b0;
                                if (r_reply_ack) begin
                                    r_state    <= RUN;
                                    r_cpu_hold <= 1'b0;
                                end else begin
                                    r_state      <= WAIT_SYNC;
                                    r_load_error <= 1'b1;
                                    r_wait_cnt   <= '0;
                                end
                            end else begin
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                                r_tx_bits  <= r_tx_bits + 1'b1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        r_cpu_hold <= 1'b0;
                        r_busy     <= 1'b0;
                        r_tx       <= 1'b1;
                    end
                    default: r_state <= WAIT_SYNC;
                endcase
            end
        end
    end

    assign boot_tx    = r_tx;
    assign cpu_hold   = r_cpu_hold;
    assign busy       = r_busy;
    assign load_error = r_load_error;
    assign imem.din   = r_din;
    assign imem.addr  = r_addr;
    assign imem.w_en  = r_w_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_boot_loader
//  Description : Scoreboard bench for uart_boot_loader (16 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset;
    logic boot_rx;
    logic boot_tx, cpu_hold, busy, load_error;

    uart_boot_loader_if #(.ADDR_W(12)) imem ();

    uart_boot_loader #(
        .F_CPU(160), .BAUD(10), .ADDR_W(12), .BOOT_WAIT(2000), .BYTE_TIMEOUT(400)
    ) dut (
        .clk(clk), .reset(reset), .boot_rx(boot_rx), .boot_tx(boot_tx),
        .imem(imem), .cpu_hold(cpu_hold), .busy(busy), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [27:0] wr_q[$];
    logic [7:0]  tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        boot_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            boot_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        boot_rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_hold_low(input int max_cycles);
        int c = 0;
        while (cpu_hold && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        check("cpu_hold_release", {31'd0, cpu_hold}, 32'd0);
    endtask

    task automatic wait_busy_low(input int max_cycles);
        int c = 0;
        while (busy && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        check("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd1);
        check({tag, "_w_en"},       {31'd0, imem.w_en},  32'd0);
        check({tag, "_addr"},       {20'd0, imem.addr},  32'd0);
        check({tag, "_din"},        {16'd0, imem.din},   32'd0);
        check({tag, "_boot_tx"},    {31'd0, boot_tx},    32'd1);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_writes_pending"}, wr_q.size(), 32'd0);
        check({tag, "_tx_pending"},     tx_q.size(), 32'd0);
    endtask

    // Write monitor: every strobe must match the next expected write and last one cycle
    initial begin : wr_mon
        logic [27:0] e;
        forever begin
            @(negedge clk);
            if (imem.w_en) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr %0h din %0h, expected no write",
                             imem.addr, imem.din);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", {20'd0, imem.addr}, {20'd0, e[27:16]});
                    check("wr_din",  {16'd0, imem.din},  {16'd0, e[15:0]});
                end
                @(negedge clk);
                check("wr_pulse_width", {31'd0, imem.w_en}, 32'd0);
            end
        end
    end

    // TX monitor: decode 8N1 by sampling mid-bit
    initial begin : tx_mon
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && boot_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = boot_tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = boot_tx;
                if (tx_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_tx: got %0h, expected no reply", b);
                end else begin
                    check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
                end
                check("tx_stop_bit", {31'd0, stop_bit}, 32'd1);
            end
        end
    end

    initial begin : stim
        int c;
        boot_rx = 1'b1;
        reset   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Good two-word image
        wr_q.push_back({12'd0, 16'h1234});
        wr_q.push_back({12'd1, 16'h5678});
        tx_q.push_back(8'h06);
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14});
        wait_hold_low(1000);
        check("ack_load_error", {31'd0, load_error}, 32'd0);
        check("ack_busy", {31'd0, busy}, 32'd0);
        check_drained("ack");

        // Bad checksum, then a good frame
        do_reset();
        wr_q.push_back({12'd0, 16'h1234});
        wr_q.push_back({12'd1, 16'h5678});
        tx_q.push_back(8'h15);
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h15});
        wait_busy_low(1000);
        check("nak_load_error", {31'd0, load_error}, 32'd1);
        check("nak_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check_drained("nak");
        wr_q.push_back({12'd0, 16'h1234});
        wr_q.push_back({12'd1, 16'h5678});
        tx_q.push_back(8'h06);
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14});
        wait_hold_low(1000);
        check("retry_load_error", {31'd0, load_error}, 32'd0);
        check_drained("retry");

        // Boot window expiry with no RX activity
        do_reset();
        c = 0;
        while (cpu_hold && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("boot_wait_window", {31'd0, (c >= 1998 && c <= 2002)}, 32'd1);
        check("boot_wait_busy", {31'd0, busy}, 32'd0);

        // Byte timeout mid-frame
        do_reset();
        tx_q.push_back(8'h15);
        send_frame('{8'hA5, 8'h01, 8'h00});
        wait_busy_low(1000);
        check("timeout_load_error", {31'd0, load_error}, 32'd1);
        check("timeout_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check_drained("timeout");

        // Back in WAIT_SYNC: LEN=4096 is accepted, then reset mid-data
        wr_q.push_back({12'd0, 16'h1234});
        send_frame('{8'hA5, 8'h00, 8'h10});
        repeat (20) @(negedge clk);
        check("len4096_busy", {31'd0, busy}, 32'd1);
        check("len4096_load_error", {31'd0, load_error}, 32'd0);
        check("len4096_boot_tx", {31'd0, boot_tx}, 32'd1);
        send_frame('{8'h34, 8'h12, 8'h78});
        check_drained("mid_data");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // LEN=4097 is refused right away, well before any timeout
        tx_q.push_back(8'h15);
        send_frame('{8'hA5, 8'h01, 8'h10});
        wait_busy_low(250);
        check("len4097_load_error", {31'd0, load_error}, 32'd1);
        check_drained("len4097");

        // Glitch and garbage before a one-word frame
        do_reset();
        boot_rx = 1'b0;
        repeat (3) @(posedge clk);
        boot_rx = 1'b1;
        repeat (40) @(posedge clk);
        wr_q.push_back({12'd0, 16'hBEEF});
        tx_q.push_back(8'h06);
        send_frame('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD});
        wait_hold_low(1000);
        check("glitch_load_error", {31'd0, load_error}, 32'd0);
        check_drained("glitch");

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
